// File: rtl/sound_beep_gen_if.sv
// Sound request / tone output bundle between the game controller and
// sound_beep_gen. The controller is the master; the beep generator is the slave.
interface sound_beep_gen_if;
  logic       enable_sound;
  logic [9:0] sound_freq;
  logic       tone_out;
  logic       busy;
  logic [3:0] beep_idx;

  modport master (
    output enable_sound, sound_freq,
    input  tone_out, busy, beep_idx
  );

  modport slave (
    input  enable_sound, sound_freq,
    output tone_out, busy, beep_idx
  );
endinterface

// File: rtl/sound_beep_gen.sv
// sound_beep_gen: turns a sound request into BEEPS square-wave bursts of
// BEEP_CYCLES clocks, each followed by GAP_CYCLES clocks of silence (none after
// the last). Tone synthesis uses a phase accumulator against HALF = CLK_HZ/2,
// so the average output frequency is exactly the requested f in Hz.
// Optional feature macro: SOUND_SWEEP_EN -- each later burst plays at
// f - (f>>2) of the previous one, giving a descending jingle.
module sound_beep_gen #(
  parameter int CLK_HZ      = 50_000_000,
  parameter int BEEP_CYCLES = 5_000_000,
  parameter int GAP_CYCLES  = 2_500_000,
  parameter int BEEPS       = 3
) (
  input logic             clk,
  input logic             resetN,
  sound_beep_gen_if.slave bus
);

  localparam int HALF    = CLK_HZ / 2;
  localparam int AW      = $clog2(HALF + 1024);
  localparam int MAX_CYC = (BEEP_CYCLES > GAP_CYCLES) ? BEEP_CYCLES : GAP_CYCLES;
  localparam int DW      = $clog2(MAX_CYC + 1);

  localparam logic [AW-1:0] HALF_V    = AW'(HALF);
  localparam logic [DW-1:0] BEEP_LAST = DW'(BEEP_CYCLES - 1);
  localparam logic [DW-1:0] GAP_LAST  = DW'(GAP_CYCLES - 1);
  localparam logic [DW-1:0] DUR_ONE   = DW'(1);
  localparam logic [3:0]    LAST_IDX  = 4'(BEEPS - 1);

  typedef enum logic [1:0] {
    IDLE,
    TONE,
    GAP
  } state_t;

  state_t        state;
  logic          en_q;
  logic [9:0]    f;
  logic [AW-1:0] acc;
  logic [DW-1:0] dur;
  logic          tone;
  logic          busy_r;
  logic [3:0]    idx;

  logic [AW-1:0] sum;
  logic          rise;

  // Next accumulator value; f < 1024 and acc < HALF, so it cannot overflow AW.
  assign sum  = acc + AW'(f);
  // Request is edge-triggered: a held-high enable_sound plays only once.
  assign rise = bus.enable_sound & ~en_q;

  assign bus.tone_out = tone;
  assign bus.busy     = busy_r;
  assign bus.beep_idx = idx;

  // Burst sequencer FSM with registered outputs and phase accumulator.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous -- it is just the highest-priority branch
    // inside the clocked block, so it only takes effect at a clk edge.
    if (!resetN) begin
      state  <= IDLE;
      en_q   <= 1'b0;
      f      <= '0;
      acc    <= '0;
      dur    <= '0;
      tone   <= 1'b0;
      busy_r <= 1'b0;
      idx    <= '0;
    end else begin
      en_q <= bus.enable_sound;
      case (state)
        IDLE: begin
          if (rise && bus.sound_freq != '0) begin
            f      <= bus.sound_freq;
            acc    <= '0;
            dur    <= '0;
            tone   <= 1'b0;
            idx    <= '0;
            busy_r <= 1'b1;
            state  <= TONE;
          end
        end

        TONE: begin
          if (sum >= HALF_V) begin
            acc  <= sum - HALF_V;
            tone <= ~tone;
          end else begin
            acc <= sum;
          end
          // NOTE: with non-blocking assignments the last one executed wins, so
          // the end-of-burst clears below override the toggle/acc updates above.
          if (dur == BEEP_LAST) begin
            tone <= 1'b0;
            acc  <= '0;
            dur  <= '0;
            if (idx == LAST_IDX) begin
              busy_r <= 1'b0;
              idx    <= '0;
              state  <= IDLE;
            end else begin
              state <= GAP;
            end
          end else begin
            dur <= dur + DUR_ONE;
          end
        end

        GAP: begin
          tone <= 1'b0;
          acc  <= '0;
          if (dur == GAP_LAST) begin
            idx   <= idx + 4'd1;
            dur   <= '0;
            state <= TONE;
`ifdef SOUND_SWEEP_EN
            // f=1 maps to 1 - 0 = 1, so the sweep never reaches silence.
            f <= f - (f >> 2);
`endif
          end else begin
            dur <= dur + DUR_ONE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sound_beep_gen.sv
// Directed bench for sound_beep_gen with CLK_HZ=1000 (HALF=500), BEEP_CYCLES=40,
// GAP_CYCLES=20, BEEPS=3. A request spans 160 busy clocks: TONE 0..39,
// GAP 40..59, TONE 60..99, GAP 100..119, TONE 120..159 (clocks after trigger).
module tb_sound_beep_gen;

  logic clk = 1'b0;
  logic resetN;
  int   n_checks = 0;
  int   n_fail   = 0;

`ifdef SOUND_SWEEP_EN
  // 100, 75, 57 Hz -> 8, 6, 4 toggles -> 4, 3, 2 rising edges.
  localparam int EXP_R1 = 3;
  localparam int EXP_R2 = 2;
  localparam int EXP_TOG = 18;
`else
  localparam int EXP_R1 = 4;
  localparam int EXP_R2 = 4;
  localparam int EXP_TOG = 24;
`endif

  sound_beep_gen_if bus ();

  sound_beep_gen #(
    .CLK_HZ     (1000),
    .BEEP_CYCLES(40),
    .GAP_CYCLES (20),
    .BEEPS      (3)
  ) dut (
    .clk   (clk),
    .resetN(resetN),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs are driven and outputs sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int bound);
    int n;
    n = 0;
    while (bus.busy === 1'b1 && n < bound) begin
      step();
      n++;
    end
    if (bus.busy !== 1'b0) begin
      $display("FAIL wait_idle: busy=%b still after %0d clks, required 0", bus.busy, bound);
      n_fail++;
    end
    n_checks++;
  endtask

  // Trigger a request at freq and observe it clock by clock until busy drops.
  // k counts clocks after the trigger edge. Optionally raises a second edge of
  // enable_sound so that it is sampled on edge k == retrig_at.
  task automatic measure(input logic [9:0] freq, input int retrig_at,
                         input logic [9:0] retrig_f,
                         output int busy_cycles, output int first_tog,
                         output int r0, output int r1, output int r2,
                         output int toggles, output int gap_bad,
                         output int idx_bad);
    logic prev;
    int   k;
    int   burst;
    logic [3:0] exp_idx;
    busy_cycles = 0; first_tog = -1; r0 = 0; r1 = 0; r2 = 0;
    toggles = 0; gap_bad = 0; idx_bad = 0;
    bus.sound_freq   = freq;
    bus.enable_sound = 1'b0;
    step();
    bus.enable_sound = 1'b1;
    step();
    k = 0;
    prev = 1'b0;
    while (k < 400) begin
      burst = (k < 60) ? 0 : ((k < 120) ? 1 : 2);
      if (bus.tone_out !== prev) begin
        toggles++;
        if (first_tog < 0) first_tog = k;
        if (bus.tone_out === 1'b1) begin
          if (burst == 0) r0++;
          else if (burst == 1) r1++;
          else r2++;
        end
      end
      prev = bus.tone_out;
      if (bus.busy !== 1'b1) break;
      busy_cycles++;
      if (k < 160) begin
        exp_idx = 4'(burst);
        if (bus.beep_idx !== exp_idx) idx_bad++;
        if (((k >= 40 && k < 60) || (k >= 100 && k < 120)) && bus.tone_out !== 1'b0)
          gap_bad++;
      end
      if (k == 1) bus.enable_sound = 1'b0;
      if (retrig_at > 0 && k == retrig_at - 2) bus.enable_sound = 1'b0;
      if (retrig_at > 0 && k == retrig_at - 1) begin
        bus.sound_freq   = retrig_f;
        bus.enable_sound = 1'b1;
      end
      step();
      k++;
    end
  endtask

  task automatic test_reset();
    resetN = 1'b0;
    bus.enable_sound = 1'b1;
    bus.sound_freq   = 10'd100;
    repeat (3) step();
    if (bus.tone_out !== 1'b0) begin
      $display("FAIL reset_tone: got %b, required 0", bus.tone_out); n_fail++;
    end
    n_checks++;
    if (bus.busy !== 1'b0) begin
      $display("FAIL reset_busy: got %b, required 0", bus.busy); n_fail++;
    end
    n_checks++;
    if (bus.beep_idx !== 4'd0) begin
      $display("FAIL reset_idx: got %0d, required 0", bus.beep_idx); n_fail++;
    end
    n_checks++;
    // en_q was cleared in reset, so a held-high enable counts as a rising edge.
    resetN = 1'b1;
    step();
    if (bus.busy !== 1'b1) begin
      $display("FAIL reset_release_trigger: busy=%b, required 1", bus.busy); n_fail++;
    end
    n_checks++;
    wait_idle(300);
    bus.enable_sound = 1'b0;
    step();
  endtask

  task automatic test_basic_burst();
    int bc, ft, r0, r1, r2, tg, gb, ib;
    measure(10'd100, -1, 10'd0, bc, ft, r0, r1, r2, tg, gb, ib);
    if (bc !== 160) begin
      $display("FAIL basic_busy_cycles: got %0d, required 160", bc); n_fail++;
    end
    n_checks++;
    if (ft !== 5) begin
      $display("FAIL basic_first_toggle: got %0d, required 5", ft); n_fail++;
    end
    n_checks++;
    if (r0 !== 4 || r1 !== EXP_R1 || r2 !== EXP_R2) begin
      $display("FAIL basic_rises: got %0d/%0d/%0d, required 4/%0d/%0d",
               r0, r1, r2, EXP_R1, EXP_R2); n_fail++;
    end
    n_checks++;
    if (tg !== EXP_TOG) begin
      $display("FAIL basic_toggles: got %0d, required %0d", tg, EXP_TOG); n_fail++;
    end
    n_checks++;
    if (gb !== 0) begin
      $display("FAIL basic_gap_silence: %0d noisy gap clks, required 0", gb); n_fail++;
    end
    n_checks++;
    if (ib !== 0) begin
      $display("FAIL basic_beep_idx: %0d wrong clks, required 0", ib); n_fail++;
    end
    n_checks++;
  endtask

  task automatic test_silent();
    int bad;
    bad = 0;
    bus.sound_freq   = 10'd0;
    bus.enable_sound = 1'b0;
    step();
    bus.enable_sound = 1'b1;
    repeat (10) begin
      step();
      if (bus.busy !== 1'b0 || bus.tone_out !== 1'b0) bad++;
    end
    if (bad !== 0) begin
      $display("FAIL silent_request: %0d active clks, required 0", bad); n_fail++;
    end
    n_checks++;
    bus.enable_sound = 1'b0;
    step();
  endtask

  task automatic test_retrigger();
    int bc, ft, r0, r1, r2, tg, gb, ib;
    measure(10'd100, 50, 10'd250, bc, ft, r0, r1, r2, tg, gb, ib);
    if (bc !== 160 || r0 !== 4 || r1 !== EXP_R1) begin
      $display("FAIL retrig_ignored: busy=%0d r0=%0d r1=%0d, required 160/4/%0d",
               bc, r0, r1, EXP_R1); n_fail++;
    end
    n_checks++;
    measure(10'd250, -1, 10'd0, bc, ft, r0, r1, r2, tg, gb, ib);
    if (ft !== 2) begin
      $display("FAIL fresh_250_first_toggle: got %0d, required 2", ft); n_fail++;
    end
    n_checks++;
    if (r0 !== 10 || bc !== 160) begin
      $display("FAIL fresh_250_burst: rises=%0d busy=%0d, required 10/160", r0, bc);
      n_fail++;
    end
    n_checks++;
  endtask

  task automatic test_reset_mid_tone();
    int bc, ft, r0, r1, r2, tg, gb, ib;
    bus.sound_freq   = 10'd100;
    bus.enable_sound = 1'b0;
    step();
    bus.enable_sound = 1'b1;
    step();
    for (int k = 1; k < 30; k++) begin
      if (k == 1) bus.enable_sound = 1'b0;
      step();
    end
    // Toggles at clks 5..25 leave tone_out high at clk 29.
    if (bus.tone_out !== 1'b1 || bus.busy !== 1'b1) begin
      $display("FAIL pre_reset_state: tone=%b busy=%b, required 1/1", bus.tone_out, bus.busy);
      n_fail++;
    end
    n_checks++;
    resetN = 1'b0;
    step();
    if (bus.tone_out !== 1'b0 || bus.busy !== 1'b0 || bus.beep_idx !== 4'd0) begin
      $display("FAIL mid_tone_reset: tone=%b busy=%b idx=%0d, required 0/0/0",
               bus.tone_out, bus.busy, bus.beep_idx); n_fail++;
    end
    n_checks++;
    resetN = 1'b1;
    step();
    if (bus.busy !== 1'b0) begin
      $display("FAIL no_tail_after_reset: busy=%b, required 0", bus.busy); n_fail++;
    end
    n_checks++;
    measure(10'd100, -1, 10'd0, bc, ft, r0, r1, r2, tg, gb, ib);
    if (bc !== 160 || ib !== 0 || ft !== 5) begin
      $display("FAIL restart_after_reset: busy=%0d idx_bad=%0d first=%0d, required 160/0/5",
               bc, ib, ft); n_fail++;
    end
    n_checks++;
  endtask

  task automatic test_back_to_back();
    int bc, ft, r0, r1, r2, tg, gb, ib;
    int bad;
    // Edge sampled on the final TONE->IDLE clock is lost.
    measure(10'd100, 160, 10'd200, bc, ft, r0, r1, r2, tg, gb, ib);
    if (bc !== 160) begin
      $display("FAIL b2b_first_request: busy=%0d, required 160", bc); n_fail++;
    end
    n_checks++;
    bad = 0;
    repeat (5) begin
      step();
      if (bus.busy !== 1'b0) bad++;
    end
    if (bad !== 0) begin
      $display("FAIL b2b_missed_trigger: %0d busy clks, required 0", bad); n_fail++;
    end
    n_checks++;
    bus.enable_sound = 1'b0;
    step();
    bus.enable_sound = 1'b1;
    step();
    if (bus.busy !== 1'b1 || bus.beep_idx !== 4'd0) begin
      $display("FAIL b2b_new_edge: busy=%b idx=%0d, required 1/0", bus.busy, bus.beep_idx);
      n_fail++;
    end
    n_checks++;
    bus.enable_sound = 1'b0;
    wait_idle(300);
  endtask

  initial begin
    test_reset();
    test_basic_burst();
    test_silent();
    test_retrigger();
    test_reset_mid_tone();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
